// File: rtl/shift_register_fifo_rv_pkg.sv
// Shared FIFO helpers: count-width derivation and per-slot load decode.
package shift_register_fifo_rv_pkg;

   typedef struct packed {
      logic load_in;     // slot captures the incoming write data
      logic load_shift;  // slot captures its upper neighbour (pop shift)
   } slot_sel_t;

   // Bits needed to hold an occupancy of 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Decide what a given slot loads this cycle. A pop shifts every
   // occupied slot above the head down by one; a push lands on the first
   // free slot after that shift, so the write index is count - pop.
   function automatic slot_sel_t slot_sel(input int idx, input int cnt,
                                          input logic push, input logic pop);
      slot_sel_t s;
      int        wr_idx;
      wr_idx       = cnt - (pop ? 1 : 0);
      s.load_in    = push && (idx == wr_idx);
      s.load_shift = pop && ((idx + 1) < cnt);
      return s;
   endfunction

endpackage

// File: rtl/shift_register_fifo_rv_if.sv
// Valid/ready stream bundle; master drives valid/data, slave drives ready.
interface shift_register_fifo_rv_if #(
   parameter int WIDTH = 8
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/shift_register_fifo_rv_slot.sv
// One FIFO storage slot: a resettable register with a load-in / shift / hold mux.
module shift_register_fifo_rv_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_in,
   input  logic             load_shift,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] up_data,
   output logic [WIDTH-1:0] q
);

   // Write data wins over the shift; the two never coincide for a legal decode.
   always_ff @(posedge clk) begin
      if (rst)             q <= '0;
      else if (load_in)    q <= in_data;
      else if (load_shift) q <= up_data;
   end

endmodule

// File: rtl/shift_register_fifo_rv.sv
// Shift-register FIFO with valid/ready on both sides; the head is always slot 0.
module shift_register_fifo_rv
   import shift_register_fifo_rv_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1,
   parameter int CNTWID    = cnt_width(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   shift_register_fifo_rv_if.slave  in_s,
   shift_register_fifo_rv_if.master out_m,
   output logic [CNTWID-1:0]       count,
   output logic                    almost_full,
   output logic                    almost_empty
);

   generate
      if (WIDTH < 1 || DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
          AE_THRESH < 0 || AE_THRESH > DEPTH - 1 || CNTWID != cnt_width(DEPTH)) begin : g_bad_param
         $error("shift_register_fifo_rv: illegal parameter combination");
      end
   endgenerate

   localparam logic [CNTWID-1:0] DEPTH_C = CNTWID'(DEPTH);
   localparam logic [CNTWID-1:0] AF_C    = CNTWID'(AF_THRESH);
   localparam logic [CNTWID-1:0] AE_C    = CNTWID'(AE_THRESH);

   logic             in_ready;
   logic             out_valid;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] slot_q [DEPTH];

   // Accepting while full is allowed only when the head leaves this same
   // cycle, hence the combinational out_ready term.
   assign out_valid = (count != '0) & ~flush & ~rst;
   assign in_ready  = ((count < DEPTH_C) | out_m.ready) & ~flush & ~rst;
   assign push      = in_s.valid & in_ready;
   assign pop       = out_valid & out_m.ready;

   assign in_s.ready  = in_ready;
   assign out_m.valid = out_valid;
   assign out_m.data  = slot_q[0];

   // Occupancy: reset and flush both empty the FIFO; otherwise track handshakes.
   always_ff @(posedge clk) begin
      if (rst)        count <= '0;
      else if (flush) count <= '0;
      else            count <= count + CNTWID'(push) - CNTWID'(pop);
   end

   // Flags come from the registered count only, so they have no input paths.
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_slot
         slot_sel_t        sel;
         logic [WIDTH-1:0] up;

         assign sel = slot_sel(i, int'(count), push, pop);

         if (i == DEPTH - 1) begin : g_top
            assign up = '0;
         end else begin : g_mid
            assign up = slot_q[i+1];
         end

         shift_register_fifo_rv_slot #(.WIDTH(WIDTH)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load_in    (sel.load_in),
            .load_shift (sel.load_shift),
            .in_data    (in_s.data),
            .up_data    (up),
            .q          (slot_q[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_shift_register_fifo_rv.sv
// Bench for shift_register_fifo_rv: directed DEPTH=8 scenarios, then random
// traffic on DEPTH=2 and DEPTH=5 instances, all against a queue scoreboard.
module tb_shift_register_fifo_rv;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit mon_en = 1'b1;

   logic [7:0] sb [3][$];

   // DUT 0: DEPTH=8, default thresholds (AF=7, AE=1)
   logic r8, f8, iv8, or8, ir8, ov8, af8, ae8;
   logic [7:0] id8, od8;
   logic [3:0] c8;
   // DUT 1: DEPTH=2, default thresholds (AF=1, AE=1)
   logic r2, f2, iv2, or2, ir2, ov2, af2, ae2;
   logic [7:0] id2, od2;
   logic [1:0] c2;
   // DUT 2: DEPTH=5, AF=3, AE=2
   logic r5, f5, iv5, or5, ir5, ov5, af5, ae5;
   logic [7:0] id5, od5;
   logic [2:0] c5;

   shift_register_fifo_rv_if #(.WIDTH(8)) in8 ();
   shift_register_fifo_rv_if #(.WIDTH(8)) out8 ();
   shift_register_fifo_rv_if #(.WIDTH(8)) in2 ();
   shift_register_fifo_rv_if #(.WIDTH(8)) out2 ();
   shift_register_fifo_rv_if #(.WIDTH(8)) in5 ();
   shift_register_fifo_rv_if #(.WIDTH(8)) out5 ();

   assign in8.valid = iv8;  assign in8.data = id8;  assign ir8 = in8.ready;
   assign out8.ready = or8; assign ov8 = out8.valid; assign od8 = out8.data;
   assign in2.valid = iv2;  assign in2.data = id2;  assign ir2 = in2.ready;
   assign out2.ready = or2; assign ov2 = out2.valid; assign od2 = out2.data;
   assign in5.valid = iv5;  assign in5.data = id5;  assign ir5 = in5.ready;
   assign out5.ready = or5; assign ov5 = out5.valid; assign od5 = out5.data;

   shift_register_fifo_rv #(.WIDTH(8), .DEPTH(8)) dut8 (
      .clk(clk), .rst(r8), .flush(f8), .in_s(in8), .out_m(out8),
      .count(c8), .almost_full(af8), .almost_empty(ae8));

   shift_register_fifo_rv #(.WIDTH(8), .DEPTH(2)) dut2 (
      .clk(clk), .rst(r2), .flush(f2), .in_s(in2), .out_m(out2),
      .count(c2), .almost_full(af2), .almost_empty(ae2));

   shift_register_fifo_rv #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2)) dut5 (
      .clk(clk), .rst(r5), .flush(f5), .in_s(in5), .out_m(out5),
      .count(c5), .almost_full(af5), .almost_empty(ae5));

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  tag, obs, obs, exp, exp, $time);
      end
   endtask

   // Reference FIFO: checks this cycle's outputs from the queue's occupancy,
   // then applies the handshakes the model itself predicts.
   task automatic model(input int k, input int depth, input int af, input int ae,
                        input bit r, input bit f, input bit iv, input logic [7:0] id,
                        input bit ordy, input int cnt_o, input bit ir_o, input bit ov_o,
                        input bit af_o, input bit ae_o, input logic [7:0] od_o);
      int mc;
      bit eir, eov, push, pop;
      mc   = sb[k].size();
      eov  = (mc != 0) && !f && !r;
      eir  = ((mc < depth) || ordy) && !f && !r;
      pop  = eov && ordy;
      push = iv && eir;
      chk($sformatf("d%0d_count", k), cnt_o, mc);
      chk($sformatf("d%0d_in_ready", k), int'(ir_o), int'(eir));
      chk($sformatf("d%0d_out_valid", k), int'(ov_o), int'(eov));
      chk($sformatf("d%0d_almost_full", k), int'(af_o), int'(mc >= af));
      chk($sformatf("d%0d_almost_empty", k), int'(ae_o), int'(mc <= ae));
      if (pop) begin
         chk($sformatf("d%0d_out_data", k), int'(od_o), int'(sb[k][0]));
         void'(sb[k].pop_front());
      end
      if (push) sb[k].push_back(id);
      if (r || f) sb[k].delete();
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         model(0, 8, 7, 1, r8, f8, iv8, id8, or8, int'(c8), ir8, ov8, af8, ae8, od8);
         model(1, 2, 1, 1, r2, f2, iv2, id2, or2, int'(c2), ir2, ov2, af2, ae2, od2);
         model(2, 5, 3, 2, r5, f5, iv5, id5, or5, int'(c5), ir5, ov5, af5, ae5, od5);
      end
   end

   task automatic drv8(input bit r, input bit f, input bit iv, input logic [7:0] d, input bit ordy);
      r8 = r; f8 = f; iv8 = iv; id8 = d; or8 = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      r8 = 1'b1; f8 = 1'b0; iv8 = 1'b1; id8 = 8'hE7; or8 = 1'b0;
      r2 = 1'b1; f2 = 1'b0; iv2 = 1'b0; id2 = 8'h00; or2 = 1'b0;
      r5 = 1'b1; f5 = 1'b0; iv5 = 1'b0; id5 = 8'h00; or5 = 1'b0;

      // Reset held two cycles with a write pending
      drv8(1, 0, 1, 8'hE7, 0);
      drv8(1, 0, 1, 8'hE7, 0);
      drv8(0, 0, 0, 8'h00, 0);
      @(negedge clk);
      chk("rst_count", int'(c8), 0);
      chk("rst_out_data", int'(od8), 0);
      chk("rst_almost_empty", int'(ae8), 1);
      chk("rst_almost_full", int'(af8), 0);

      // Fill with 0x01..0x08, consumer stalled
      for (int i = 1; i <= 8; i++) drv8(0, 0, 1, 8'(i), 0);
      r8 = 1'b0; iv8 = 1'b0;
      @(negedge clk);
      chk("full_count", int'(c8), 8);
      chk("full_in_ready", int'(ir8), 0);
      chk("full_almost_full", int'(af8), 1);

      // Push while full with a simultaneous pop
      drv8(0, 0, 1, 8'hAA, 1);
      @(negedge clk);
      chk("fullpp_count", int'(c8), 8);

      // Drain; scoreboard expects 0x02..0x08 then 0xAA
      for (int i = 0; i < 9; i++) drv8(0, 0, 0, 8'h00, 1);
      @(negedge clk);
      chk("drain_count", int'(c8), 0);

      // Push into an empty FIFO with out_ready high: no fall-through
      drv8(0, 0, 1, 8'h5C, 1);
      drv8(0, 0, 0, 8'h00, 0);
      @(negedge clk);
      chk("empty_push_valid", int'(ov8), 1);
      chk("empty_push_data", int'(od8), 'h5C);
      chk("empty_push_count", int'(c8), 1);
      drv8(0, 0, 0, 8'h00, 1);

      // Flush with both handshakes requested
      for (int i = 0; i < 5; i++) drv8(0, 0, 1, 8'(8'h10 + i), 0);
      drv8(0, 1, 1, 8'h99, 1);
      @(negedge clk);
      chk("flush_count", int'(c8), 0);
      drv8(0, 0, 1, 8'h33, 0);
      drv8(0, 0, 0, 8'h00, 0);
      @(negedge clk);
      chk("post_flush_data", int'(od8), 'h33);
      drv8(0, 0, 0, 8'h00, 1);

      // Reset in the middle of a push+pop
      for (int i = 0; i < 3; i++) drv8(0, 0, 1, 8'(8'h40 + i), 0);
      drv8(1, 0, 1, 8'h77, 1);
      drv8(0, 0, 0, 8'h00, 0);
      @(negedge clk);
      chk("midrst_count", int'(c8), 0);
      chk("midrst_out_data", int'(od8), 0);

      // Random traffic on the DEPTH=2 and DEPTH=5 instances
      drv8(0, 0, 0, 8'h00, 0);
      for (int n = 0; n < 10000; n++) begin
         int pv, pr;
         pv = 20 + 15 * ((n / 1000) % 5);
         pr = 90 - 15 * ((n / 700) % 5);
         r2  = ($urandom_range(0, 499) == 0);
         f2  = ($urandom_range(0, 63) == 0);
         iv2 = ($urandom_range(0, 99) < pv);
         or2 = ($urandom_range(0, 99) < pr);
         id2 = 8'($urandom);
         r5  = ($urandom_range(0, 499) == 0);
         f5  = ($urandom_range(0, 63) == 0);
         iv5 = ($urandom_range(0, 99) < pr);
         or5 = ($urandom_range(0, 99) < pv);
         id5 = 8'($urandom);
         @(posedge clk);
         #1;
      end

      @(negedge clk);
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
